pid_ctrl_pipe: RTL

- Parametrised, pipelined successor to the single-channel fixed-width digital PID.
- Once per accepted error sample, computes the control word n_con = P + I + D from signed error and run-time gains.
- Adds generic widths, a valid handshake, enable, integrator clear, and symmetric integrator clamping with conditional-integration anti-windup.
- Adds output saturation with status flags; sits between the error ADC/comparator path and the PWM duty generator.

---
 rtl/pid_ctrl_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pid_ctrl_pipe.sv
// pid_ctrl_pipe: two-stage pipelined PID controller, n_con = P + I + D.
// Stage 1 captures gains and error products at the accept edge.
// Stage 2 updates the clamped integrator (with conditional-integration
// anti-windup), sums the three terms and saturates the control word.
// Optional macro PID_CTRL_DERIV_FILTER_EN adds a first-order low-pass on
// the derivative term (shift D_SHIFT); without it the raw derivative is used.
// Handshake: a sample is taken when in_valid && en at a rising f_pwm edge;
// there is no backpressure, and out_valid pulses for one cycle two edges
// later with n_con/out_sat/int_sat updated (they hold otherwise).
module pid_ctrl_pipe #(
    parameter int EW      = 10,
    parameter int GW      = 10,
    parameter int OUT_W   = 19,
    parameter int ACC_W   = 24,
    parameter int I_SHIFT = 3,
    parameter int I_MAX   = (1 << (ACC_W - 1)) - 1
`ifdef PID_CTRL_DERIV_FILTER_EN
    , parameter int D_SHIFT = 2
`endif
) (
    input  logic                    f_pwm,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr_int,
    input  logic                    in_valid,
    input  logic signed [EW-1:0]    n_er,
    input  logic signed [GW-1:0]    k_p,
    input  logic signed [GW-1:0]    k_i,
    input  logic signed [GW-1:0]    k_d,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] n_con,
    output logic                    out_sat,
    output logic                    int_sat
);
    localparam int PW = EW + GW;          // P and integrator increment width
    localparam int DW = EW + GW + 1;      // derivative width (difference is EW+1)
    localparam int AW = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam int MW = (DW > ACC_W) ? DW : ACC_W;
    localparam int SW = ((MW > OUT_W) ? MW : OUT_W) + 2;

    localparam logic signed [AW-1:0] LIM_HI = AW'(I_MAX);
    localparam logic signed [AW-1:0] LIM_LO = -LIM_HI;
    localparam logic signed [SW-1:0] OUT_HI = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OUT_LO = ~OUT_HI;

    // stage 1 registers
    logic                    r_v1;
    logic signed [PW-1:0]    r_p;
    logic signed [PW-1:0]    r_inc;
    logic signed [EW-1:0]    r_e_prev;
    // stage 2 state
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_accept;
    logic signed [EW-1:0]    w_e_base;
    logic signed [EW:0]      w_e_diff;
    logic signed [PW-1:0]    w_p;
    logic signed [PW-1:0]    w_inc;
    logic signed [DW-1:0]    w_d;
    logic signed [DW-1:0]    w_d_use;

    // Stage-1 arithmetic: products and first difference of the incoming sample
    always_comb begin
        w_accept = in_valid && en;
        w_e_base = clr_int ? '0 : r_e_prev;
        w_e_diff = (EW+1)'(n_er) - (EW+1)'(w_e_base);
        w_p      = PW'(n_er) * PW'(k_p);
        w_inc    = PW'(n_er) * PW'(k_i);
        w_d      = DW'(w_e_diff) * DW'(k_d);
    end

`ifdef PID_CTRL_DERIV_FILTER_EN
    logic signed [DW-1:0] r_df;
    logic signed [DW-1:0] w_df_base;
    logic signed [DW:0]   w_df_delta;
    logic signed [DW-1:0] w_df_nx;

    // Derivative low-pass: move the filter state 1/2^D_SHIFT of the way to d
    always_comb begin
        w_df_base  = clr_int ? '0 : r_df;
        w_df_delta = (DW+1)'(w_d) - (DW+1)'(w_df_base);
        w_df_nx    = DW'((DW+1)'(w_df_base) + (w_df_delta >>> D_SHIFT));
        w_d_use    = r_df;
    end
`else
    logic signed [DW-1:0] r_d;

    // Raw derivative feeds stage 2 directly
    always_comb begin
        w_d_use = r_d;
    end
`endif

    // Stage-1 register: capture products on accept, clear history on clr_int
    always_ff @(posedge f_pwm or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_p      <= '0;
            r_inc    <= '0;
            r_e_prev <= '0;
`ifdef PID_CTRL_DERIV_FILTER_EN
            r_df     <= '0;
`else
            r_d      <= '0;
`endif
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_p      <= w_p;
                r_inc    <= w_inc;
                r_e_prev <= n_er;
`ifdef PID_CTRL_DERIV_FILTER_EN
                r_df     <= w_df_nx;
`else
                r_d      <= w_d;
`endif
            end else if (clr_int) begin
                r_e_prev <= '0;
`ifdef PID_CTRL_DERIV_FILTER_EN
                r_df     <= '0;
`endif
            end
        end
    end

    logic                    w_hold;
    logic signed [AW-1:0]    w_acc_sum;
    logic signed [AW-1:0]    w_acc_clip;
    logic signed [ACC_W-1:0] w_acc_nx;
    logic signed [ACC_W-1:0] w_i_term;
    logic signed [SW-1:0]    w_sum;
    logic signed [OUT_W-1:0] w_con_nx;
    logic                    w_out_sat_nx;
    logic                    w_int_sat_nx;

    // Stage-2 arithmetic: anti-windup, integrator clamp, sum and output clip
    always_comb begin
        w_hold    = out_sat && (r_inc != '0) && (r_inc[PW-1] == n_con[OUT_W-1]);
        w_acc_sum = AW'(r_acc) + (w_hold ? AW'(0) : AW'(r_inc));
        if (clr_int)
            w_acc_clip = '0;
        else if (w_acc_sum > LIM_HI)
            w_acc_clip = LIM_HI;
        else if (w_acc_sum < LIM_LO)
            w_acc_clip = LIM_LO;
        else
            w_acc_clip = w_acc_sum;
        w_acc_nx     = ACC_W'(w_acc_clip);
        w_int_sat_nx = (w_acc_clip == LIM_HI) || (w_acc_clip == LIM_LO);
        w_i_term     = w_acc_nx >>> I_SHIFT;
        w_sum        = SW'(r_p) + SW'(w_i_term) + SW'(w_d_use);
        w_out_sat_nx = 1'b1;
        if (w_sum > OUT_HI)
            w_con_nx = OUT_HI[OUT_W-1:0];
        else if (w_sum < OUT_LO)
            w_con_nx = OUT_LO[OUT_W-1:0];
        else begin
            w_con_nx     = OUT_W'(w_sum);
            w_out_sat_nx = 1'b0;
        end
    end

    // Stage-2 register: publish result, update or clear the integrator
    always_ff @(posedge f_pwm or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            n_con     <= '0;
            out_sat   <= 1'b0;
            int_sat   <= 1'b0;
            r_acc     <= '0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                n_con   <= w_con_nx;
                out_sat <= w_out_sat_nx;
                int_sat <= w_int_sat_nx;
            end
            if (clr_int || r_v1)
                r_acc <= w_acc_nx;
        end
    end
endmodule
